channel_burst_injector: RTL and testbench
=========================================

# channel_burst_injector

Parametrised channel model between the convolutional encoder and the Viterbi decoder. It replaces ad-hoc inline error injection with a configurable burst-error generator. Each valid W-bit code symbol passes through one register stage. Periodic bursts of corrupted symbols are injected using a selectable mask mode (all-bit, pseudo-random LFSR, or rotating single-bit). Saturating counters report the number of symbols, corrupted symbols and flipped bits, so the bench can relate decoder output errors to channel bit error rate.

## Interface
- W, 2: symbol width (code rate 1/W); legal 1..8
- PERIOD_W, 8: width of cfg_period
- MAX_BURST, 4: upper clamp on burst length
- CNT_W, 16: width of each statistics counter
- SEED, 16'hACE1: LFSR reset/reload value; must be nonzero
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- cfg_period  in  PERIOD_W  symbols per burst period; 0 disables injection
- cfg_burst_len  in  4  corrupted symbols at the start of each period
- cfg_mode  in  2  0 off, 1 invert all bits, 2 LFSR mask, 3 rotating one-hot
- cfg_load  in  1  single-cycle pulse; latches cfg_*, clears counters, resets phase and LFSR
- in_valid  in  1  in_sym is a valid encoder symbol this cycle
- in_sym  in  W  encoder output symbol
- out_valid  out  1  registered in_valid
- out_sym  out  W  in_sym XOR applied mask, registered
- out_err  out  1  nonzero mask was applied to out_sym
- sym_count  out  CNT_W  valid symbols since last cfg_load/reset
- err_sym_count  out  CNT_W  corrupted symbols
- err_bit_count  out  CNT_W  total flipped bits

## Operation
- Active configuration: internal copies of period, burst length and mode. These are updated only on cfg_load. Reset values are period 0, burst 1, mode 0.
- Effective burst length L = max(1, min(cfg_burst_len, MAX_BURST, period)).
- Phase counter k (PERIOD_W bits) advances once per accepted in_valid and wraps from period-1 to 0. Symbols with k < L are burst symbols.
- FSM states:
  - IDLE: entered when mode is 0 or period is 0. No corruption; k is held at 0.
  - BURST: k < L.
  - GAP: k >= L.
- Transitions are evaluated only on valid symbols:
  - BURST→GAP when k = L-1 and L < period.
  - GAP→BURST on wrap.
  - BURST stays in BURST on wrap when L = period (continuous corruption).
  - cfg_load goes to BURST with k = 0, or to IDLE if the new config disables injection.
- Mask for burst symbols:
  - Mode 1: all ones.
  - Mode 2: lfsr[W-1:0]. If this is zero, {W-1 zeros, 1} is used instead, so every burst symbol is corrupted.
  - Mode 3: one-hot value that starts at bit 0 on each burst start and rotates left by one per burst symbol (mod W).
  - Non-burst symbols and IDLE use a zero mask.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Steps once per valid symbol in every state. It is reloaded to SEED on reset and on cfg_load.
- Counters saturate at all ones and never wrap:
  - sym_count increments by 1 per valid symbol.
  - err_sym_count increments by 1 per corrupted symbol.
  - err_bit_count increments by popcount(mask).
- Simultaneous cfg_load and in_valid: cfg_load has priority. That symbol is forwarded uncorrupted with out_err = 0, is not counted, and does not advance k or the LFSR. The next valid symbol is index k = 0 under the new configuration.
- cfg_load during a burst aborts the burst immediately.

## Timing
- Latency is exactly 1 cycle from in_valid/in_sym to out_valid/out_sym/out_err. There is no backpressure; one symbol per cycle is accepted.
- Counters reflect a symbol in the same cycle its out_valid is high.
- cfg_load takes effect for symbols presented on the following cycle or later. Counters read 0 in the cycle after cfg_load.
- Reset (asynchronous, any time) forces:
  - out_valid = 0, out_sym = 0, out_err = 0, all counters = 0
  - k = 0, FSM = IDLE, LFSR = SEED, active config = reset values
- Gaps in in_valid freeze k, the LFSR, the rotate pointer and the FSM.

## Structure
- Package chan_pkg holds:
  - mode enum (MODE_OFF, MODE_INV, MODE_LFSR, MODE_ROT)
  - FSM state enum (ST_IDLE, ST_BURST, ST_GAP)
  - LFSR polynomial constant 16'hB400
  - popcount function
- Sub-module chan_lfsr16 (ports clk, rst, load, step, seed, q) is reused by the bench stimulus generator.
- The top level contains the config registers, FSM, mask mux, output register and counters.

## Test plan
- Reset, then cfg_load period=16, burst_len=1, mode=1, W=2, with 64 contiguous valid symbols of 2'b00. Required: out_sym = 2'b11 at indices 0, 16, 32, 48 only; err_sym_count = 4, err_bit_count = 8, sym_count = 64.
- Period 8, burst_len 6 (MAX_BURST 4), mode 3, 16 symbols of 00. Required: L clamps to 4; masks 01, 10, 01, 10 at indices 0-3 and 8-11; err_bit_count = 8.
- Mode 2 with the default SEED, 32 symbols. Required: out_sym matches a reference LFSR model bit-exactly, the forced-nonzero rule holds, and out_err is high on every burst symbol.
- cfg_load asserted together with in_valid mid-burst. Required: that symbol is uncorrupted and uncounted, counters are 0 on the next cycle, and the next valid symbol is a burst start.
- in_valid toggling 1-0-1 with period 4, burst 2. Required: the corruption pattern follows the valid-symbol index, not the cycle count.
- With CNT_W=4, run 20 all-corrupted symbols (period = burst = 1, mode 1). Required: err_sym_count saturates at 15. Assert rst mid-stream: all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/chan_pkg.sv
// Shared types and helpers for the channel burst injector.
package chan_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_INV  = 2'd1,
      MODE_LFSR = 2'd2,
      MODE_ROT  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Galois LFSR with synchronous reload and step enable.
module chan_lfsr16
   import chan_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   // Next state: reload wins over step.
   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = seed;
      end else if (step) begin
         q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_POLY : 16'h0000);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/channel_burst_injector.sv
// Registered channel model injecting periodic burst errors into code symbols.
module channel_burst_injector
   import chan_pkg::*;
#(
   parameter int unsigned W         = 2,
   parameter int unsigned PERIOD_W  = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 16,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [3:0]          cfg_burst_len,
   input  logic [1:0]          cfg_mode,
   input  logic                cfg_load,
   input  logic                in_valid,
   input  logic [W-1:0]        in_sym,
   output logic                out_valid,
   output logic [W-1:0]        out_sym,
   output logic                out_err,
   output logic [CNT_W-1:0]    sym_count,
   output logic [CNT_W-1:0]    err_sym_count,
   output logic [CNT_W-1:0]    err_bit_count
);

   logic [PERIOD_W-1:0] period_q, period_d;
   logic [3:0]          burst_q, burst_d;
   mode_e               mode_q, mode_d;
   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] k_q, k_d;
   logic [W-1:0]        rot_q, rot_d;
   logic                out_valid_q, out_valid_d;
   logic [W-1:0]        out_sym_q, out_sym_d;
   logic                out_err_q, out_err_d;
   logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
   logic [CNT_W-1:0]    esym_cnt_q, esym_cnt_d;
   logic [CNT_W-1:0]    ebit_cnt_q, ebit_cnt_d;

   logic [15:0]         lfsr_q;
   logic                accept;
   logic                k_last;
   logic [31:0]         eff_len;
   logic [W-1:0]        mask;
   logic [W-1:0]        mask_eff;
   logic                unused_lfsr_hi;

   // A load cycle consumes the symbol as a plain pass-through.
   assign accept = in_valid & ~cfg_load;

   chan_lfsr16 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (cfg_load),
      .step (accept),
      .seed (SEED),
      .q    (lfsr_q)
   );

   assign unused_lfsr_hi = ^lfsr_q[15:W];

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W - 3){1'b0}}, inc};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   // Effective burst length L = max(1, min(burst, MAX_BURST, period)).
   always_comb begin
      eff_len = 32'(burst_q);
      if (eff_len > MAX_BURST) eff_len = MAX_BURST;
      if (eff_len > 32'(period_q)) eff_len = 32'(period_q);
      if (eff_len == 32'd0) eff_len = 32'd1;
      k_last = (32'(k_q) == 32'(period_q) - 32'd1);
   end

   // Mask selection; only burst symbols are corrupted.
   always_comb begin
      mask = '0;
      if (state_q == ST_BURST) begin
         unique case (mode_q)
            MODE_OFF:  mask = '0;
            MODE_INV:  mask = '1;
            MODE_LFSR: mask = (lfsr_q[W-1:0] == '0) ? W'(1) : lfsr_q[W-1:0];
            MODE_ROT:  mask = rot_q;
         endcase
      end
      mask_eff = accept ? mask : '0;
   end

   // Config, phase, rotate pointer and FSM next state.
   always_comb begin
      period_d = period_q;
      burst_d  = burst_q;
      mode_d   = mode_q;
      state_d  = state_q;
      k_d      = k_q;
      rot_d    = rot_q;
      if (cfg_load) begin
         period_d = cfg_period;
         burst_d  = cfg_burst_len;
         mode_d   = mode_e'(cfg_mode);
         k_d      = '0;
         rot_d    = W'(1);
         state_d  = (cfg_mode == 2'd0 || cfg_period == '0) ? ST_IDLE : ST_BURST;
      end else if (in_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               k_d = '0;
            end
            ST_BURST: begin
               rot_d = (rot_q << 1) | (rot_q >> (W - 1));
               if (k_last) begin
                  // L == period: stay corrupting, restart rotation
                  k_d   = '0;
                  rot_d = W'(1);
               end else begin
                  k_d = k_q + 1'b1;
                  if (32'(k_q) == eff_len - 32'd1) state_d = ST_GAP;
               end
            end
            ST_GAP: begin
               if (k_last) begin
                  k_d     = '0;
                  rot_d   = W'(1);
                  state_d = ST_BURST;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output stage and saturating statistics.
   always_comb begin
      out_valid_d = in_valid;
      out_sym_d   = in_sym ^ mask_eff;
      out_err_d   = |mask_eff;
      sym_cnt_d   = sym_cnt_q;
      esym_cnt_d  = esym_cnt_q;
      ebit_cnt_d  = ebit_cnt_q;
      if (cfg_load) begin
         sym_cnt_d  = '0;
         esym_cnt_d = '0;
         ebit_cnt_d = '0;
      end else if (accept) begin
         sym_cnt_d  = sat_add(sym_cnt_q, 4'd1);
         esym_cnt_d = sat_add(esym_cnt_q, {3'd0, |mask_eff});
         ebit_cnt_d = sat_add(ebit_cnt_q, popcount(8'(mask_eff)));
      end
   end

   // All state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_q    <= '0;
         burst_q     <= 4'd1;
         mode_q      <= MODE_OFF;
         state_q     <= ST_IDLE;
         k_q         <= '0;
         rot_q       <= W'(1);
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_err_q   <= 1'b0;
         sym_cnt_q   <= '0;
         esym_cnt_q  <= '0;
         ebit_cnt_q  <= '0;
      end else begin
         period_q    <= period_d;
         burst_q     <= burst_d;
         mode_q      <= mode_d;
         state_q     <= state_d;
         k_q         <= k_d;
         rot_q       <= rot_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_err_q   <= out_err_d;
         sym_cnt_q   <= sym_cnt_d;
         esym_cnt_q  <= esym_cnt_d;
         ebit_cnt_q  <= ebit_cnt_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_sym       = out_sym_q;
   assign out_err       = out_err_q;
   assign sym_count     = sym_cnt_q;
   assign err_sym_count = esym_cnt_q;
   assign err_bit_count = ebit_cnt_q;

endmodule

// File: tb/tb_channel_burst_injector.sv
// Directed self-checking bench for channel_burst_injector.
module tb_channel_burst_injector;

   logic        clk;
   logic        rst;
   logic [7:0]  cfg_period;
   logic [3:0]  cfg_burst_len;
   logic [1:0]  cfg_mode;
   logic        cfg_load;
   logic        in_valid;
   logic [1:0]  in_sym;

   logic        out_valid;
   logic [1:0]  out_sym;
   logic        out_err;
   logic [15:0] sym_count;
   logic [15:0] err_sym_count;
   logic [15:0] err_bit_count;

   logic        s_out_valid;
   logic [1:0]  s_out_sym;
   logic        s_out_err;
   logic [3:0]  s_sym_count;
   logic [3:0]  s_err_sym_count;
   logic [3:0]  s_err_bit_count;

   int total;
   int bad;

   channel_burst_injector #(
      .W         (2),
      .PERIOD_W  (8),
      .MAX_BURST (4),
      .CNT_W     (16),
      .SEED      (16'hACE1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_period    (cfg_period),
      .cfg_burst_len (cfg_burst_len),
      .cfg_mode      (cfg_mode),
      .cfg_load      (cfg_load),
      .in_valid      (in_valid),
      .in_sym        (in_sym),
      .out_valid     (out_valid),
      .out_sym       (out_sym),
      .out_err       (out_err),
      .sym_count     (sym_count),
      .err_sym_count (err_sym_count),
      .err_bit_count (err_bit_count)
   );

   // Narrow-counter copy sharing the same stimulus, for saturation.
   channel_burst_injector #(
      .W         (2),
      .PERIOD_W  (8),
      .MAX_BURST (4),
      .CNT_W     (4),
      .SEED      (16'hACE1)
   ) dut_sat (
      .clk           (clk),
      .rst           (rst),
      .cfg_period    (cfg_period),
      .cfg_burst_len (cfg_burst_len),
      .cfg_mode      (cfg_mode),
      .cfg_load      (cfg_load),
      .in_valid      (in_valid),
      .in_sym        (in_sym),
      .out_valid     (s_out_valid),
      .out_sym       (s_out_sym),
      .out_err       (s_out_err),
      .sym_count     (s_sym_count),
      .err_sym_count (s_err_sym_count),
      .err_bit_count (s_err_bit_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      logic [15:0] n;
      n = l >> 1;
      if (l[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Clock one cycle with the given inputs, then sample 1 time unit later.
   task automatic send(input logic v, input logic [1:0] s);
      in_valid = v;
      in_sym   = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] p, input logic [3:0] b, input logic [1:0] m);
      cfg_period    = p;
      cfg_burst_len = b;
      cfg_mode      = m;
      cfg_load      = 1'b1;
      send(1'b0, 2'b00);
      cfg_load = 1'b0;
      total++;
      if (sym_count !== 16'd0 || err_sym_count !== 16'd0 || err_bit_count !== 16'd0) begin
         bad++;
         $display("FAIL load_clear: counts %0d/%0d/%0d, required 0/0/0",
                  sym_count, err_sym_count, err_bit_count);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      cfg_period = 8'd0; cfg_burst_len = 4'd0; cfg_mode = 2'd0; cfg_load = 1'b0;
      in_valid = 1'b0; in_sym = 2'b00;
      #12;
      total++;
      if (out_valid !== 1'b0 || out_sym !== 2'b00 || out_err !== 1'b0 ||
          sym_count !== 16'd0 || err_sym_count !== 16'd0 || err_bit_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_state: v=%b s=%b e=%b cnt=%0d/%0d/%0d, required all 0",
                  out_valid, out_sym, out_err, sym_count, err_sym_count, err_bit_count);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      // Default config is disabled: symbols pass untouched.
      send(1'b1, 2'b10);
      total++;
      if (out_valid !== 1'b1 || out_sym !== 2'b10 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL idle_pass: v=%b s=%b e=%b, required 1 10 0", out_valid, out_sym, out_err);
      end
   endtask

   task automatic test_invert;
      logic [1:0] exp;
      do_load(8'd16, 4'd1, 2'd1);
      for (int i = 0; i < 64; i++) begin
         send(1'b1, 2'b00);
         exp = (i % 16 == 0) ? 2'b11 : 2'b00;
         total++;
         if (out_valid !== 1'b1 || out_sym !== exp || out_err !== (exp != 2'b00)) begin
            bad++;
            $display("FAIL invert[%0d]: v=%b s=%b e=%b, required 1 %b %b",
                     i, out_valid, out_sym, out_err, exp, exp != 2'b00);
         end
      end
      total++;
      if (sym_count !== 16'd64 || err_sym_count !== 16'd4 || err_bit_count !== 16'd8) begin
         bad++;
         $display("FAIL invert_counts: %0d/%0d/%0d, required 64/4/8",
                  sym_count, err_sym_count, err_bit_count);
      end
   endtask

   task automatic test_rotate;
      logic [1:0] exp;
      do_load(8'd8, 4'd6, 2'd3);
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 2'b00);
         if (i % 8 < 4) exp = ((i % 8) % 2 == 0) ? 2'b01 : 2'b10;
         else exp = 2'b00;
         total++;
         if (out_sym !== exp || out_err !== (exp != 2'b00)) begin
            bad++;
            $display("FAIL rotate[%0d]: s=%b e=%b, required %b %b",
                     i, out_sym, out_err, exp, exp != 2'b00);
         end
      end
      total++;
      if (err_bit_count !== 16'd8 || err_sym_count !== 16'd8) begin
         bad++;
         $display("FAIL rotate_counts: bits=%0d syms=%0d, required 8 8",
                  err_bit_count, err_sym_count);
      end
   endtask

   task automatic test_lfsr;
      logic [15:0] l;
      logic [1:0]  m;
      logic [1:0]  s;
      logic [1:0]  exp;
      int          ebits;
      int          esyms;
      l = 16'hACE1;
      ebits = 0;
      esyms = 0;
      do_load(8'd3, 4'd2, 2'd2);
      for (int i = 0; i < 32; i++) begin
         s = 2'(i);
         m = 2'b00;
         if (i % 3 < 2) begin
            m = l[1:0];
            if (m == 2'b00) m = 2'b01;
            esyms++;
            ebits += int'(m[0]) + int'(m[1]);
         end
         exp = s ^ m;
         send(1'b1, s);
         total++;
         if (out_sym !== exp || out_err !== (m != 2'b00)) begin
            bad++;
            $display("FAIL lfsr[%0d]: s=%b e=%b, required %b %b", i, out_sym, out_err,
                     exp, m != 2'b00);
         end
         l = lfsr_next(l);
      end
      total++;
      if (err_sym_count !== 16'(esyms) || err_bit_count !== 16'(ebits)) begin
         bad++;
         $display("FAIL lfsr_counts: %0d/%0d, required %0d/%0d",
                  err_sym_count, err_bit_count, esyms, ebits);
      end
   endtask

   task automatic test_load_mid_burst;
      logic [1:0] exp;
      do_load(8'd8, 4'd4, 2'd1);
      send(1'b1, 2'b00);
      send(1'b1, 2'b00);
      // Third burst symbol arrives together with a reload.
      cfg_load = 1'b1;
      send(1'b1, 2'b00);
      cfg_load = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_sym !== 2'b00 || out_err !== 1'b0 ||
          sym_count !== 16'd0 || err_sym_count !== 16'd0 || err_bit_count !== 16'd0) begin
         bad++;
         $display("FAIL load_valid: v=%b s=%b e=%b cnt=%0d/%0d/%0d, required 1 00 0 0/0/0",
                  out_valid, out_sym, out_err, sym_count, err_sym_count, err_bit_count);
      end
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 2'b00);
         exp = (i < 4) ? 2'b11 : 2'b00;
         total++;
         if (out_sym !== exp) begin
            bad++;
            $display("FAIL after_load[%0d]: s=%b, required %b", i, out_sym, exp);
         end
      end
      total++;
      if (sym_count !== 16'd5 || err_sym_count !== 16'd4 || err_bit_count !== 16'd8) begin
         bad++;
         $display("FAIL after_load_counts: %0d/%0d/%0d, required 5/4/8",
                  sym_count, err_sym_count, err_bit_count);
      end
   endtask

   task automatic test_valid_gaps;
      logic       v;
      logic [1:0] exp;
      int         j;
      j = 0;
      do_load(8'd4, 4'd2, 2'd1);
      for (int c = 0; c < 16; c++) begin
         v = (c % 2 == 0);
         send(v, 2'b00);
         total++;
         if (out_valid !== v) begin
            bad++;
            $display("FAIL gap_valid[%0d]: v=%b, required %b", c, out_valid, v);
         end
         if (v) begin
            exp = (j % 4 < 2) ? 2'b11 : 2'b00;
            total++;
            if (out_sym !== exp) begin
               bad++;
               $display("FAIL gap_sym[%0d]: s=%b, required %b", j, out_sym, exp);
            end
            j++;
         end
      end
      total++;
      if (sym_count !== 16'd8 || err_sym_count !== 16'd4) begin
         bad++;
         $display("FAIL gap_counts: %0d/%0d, required 8/4", sym_count, err_sym_count);
      end
   endtask

   task automatic test_saturate_and_async_reset;
      do_load(8'd1, 4'd1, 2'd1);
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 2'b01);
         total++;
         if (s_out_sym !== 2'b10 || s_out_err !== 1'b1) begin
            bad++;
            $display("FAIL sat_sym[%0d]: s=%b e=%b, required 10 1", i, s_out_sym, s_out_err);
         end
      end
      total++;
      if (s_err_sym_count !== 4'd15 || s_sym_count !== 4'd15 || s_err_bit_count !== 4'd15) begin
         bad++;
         $display("FAIL saturate: %0d/%0d/%0d, required 15/15/15",
                  s_sym_count, s_err_sym_count, s_err_bit_count);
      end
      total++;
      if (sym_count !== 16'd20 || err_sym_count !== 16'd20 || err_bit_count !== 16'd40) begin
         bad++;
         $display("FAIL wide_counts: %0d/%0d/%0d, required 20/20/40",
                  sym_count, err_sym_count, err_bit_count);
      end
      in_valid = 1'b1;
      #3;
      rst = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_sym !== 2'b00 || out_err !== 1'b0 ||
          sym_count !== 16'd0 || err_sym_count !== 16'd0 || err_bit_count !== 16'd0 ||
          s_out_valid !== 1'b0 || s_err_sym_count !== 4'd0) begin
         bad++;
         $display("FAIL async_reset: v=%b s=%b e=%b cnt=%0d/%0d/%0d sat=%0d, required all 0",
                  out_valid, out_sym, out_err, sym_count, err_sym_count, err_bit_count,
                  s_err_sym_count);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_invert();
      test_rotate();
      test_lfsr();
      test_load_mid_burst();
      test_valid_gaps();
      test_saturate_and_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
